// File: rtl/rf_write_arbiter.sv
// Round-robin arbiter for the shared register-file write port.
// One request accepted per cycle; the write pulse to the register file is registered. Writes to x0 are accepted but produce no write.
module rf_write_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int XLEN    = 32,
  parameter int ADDR_W  = 5,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req_valid_i,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr_i,
  input  logic [NUM_REQ*XLEN-1:0]   req_data_i,
  output logic [NUM_REQ-1:0]        req_ready_o,
  output logic                      rf_wr_en_o,
  output logic [ADDR_W-1:0]         rf_addr_o,
  output logic [XLEN-1:0]           rf_data_o,
  output logic [IDX_W-1:0]          grant_idx_o
);

  logic [IDX_W-1:0]  ptr_q;
  logic [IDX_W-1:0]  win_idx;
  logic [IDX_W-1:0]  cand_idx;
  logic              win_found;
  logic [NUM_REQ-1:0] grant;
  logic [ADDR_W-1:0] addr_arr [NUM_REQ];
  logic [XLEN-1:0]   data_arr [NUM_REQ];

  always_comb begin
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      addr_arr[k] = req_addr_i[k*ADDR_W +: ADDR_W];
      data_arr[k] = req_data_i[k*XLEN +: XLEN];
    end
  end

  // Search starts just after the last winner and wraps; first valid wins.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand_idx  = '0;
    grant     = '0;
    for (int unsigned i = 1; i <= NUM_REQ; i++) begin
      cand_idx = IDX_W'((32'(ptr_q) + i) % NUM_REQ);
      if (!win_found && req_valid_i[cand_idx]) begin
        win_found = 1'b1;
        win_idx   = cand_idx;
      end
    end
    if (win_found) begin
      grant[win_idx] = 1'b1;
    end
  end

  assign req_ready_o = rst_n ? grant : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q       <= IDX_W'(NUM_REQ - 1);
      rf_wr_en_o  <= 1'b0;
      rf_addr_o   <= '0;
      rf_data_o   <= '0;
      grant_idx_o <= '0;
    end else if (win_found) begin
      ptr_q       <= win_idx;
      rf_wr_en_o  <= (addr_arr[win_idx] != '0);
      rf_addr_o   <= addr_arr[win_idx];
      rf_data_o   <= data_arr[win_idx];
      grant_idx_o <= win_idx;
    end else begin
      rf_wr_en_o  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Scoreboard bench for rf_write_arbiter: a bench-side round-robin model predicts
// the grant and pushes the expected registered outputs for the following cycle.
module tb_rf_write_arbiter;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [3:0]   req_valid_i = '0;
  logic [19:0]  req_addr_i = '0;
  logic [127:0] req_data_i = '0;
  logic [3:0]   req_ready_o;
  logic         rf_wr_en_o;
  logic [4:0]   rf_addr_o;
  logic [31:0]  rf_data_o;
  logic [1:0]   grant_idx_o;

  rf_write_arbiter #(.NUM_REQ(4), .XLEN(32), .ADDR_W(5)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid_i(req_valid_i), .req_addr_i(req_addr_i), .req_data_i(req_data_i),
    .req_ready_o(req_ready_o), .rf_wr_en_o(rf_wr_en_o), .rf_addr_o(rf_addr_o),
    .rf_data_o(rf_data_o), .grant_idx_o(grant_idx_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        en;
    logic [4:0]  addr;
    logic [31:0] data;
    logic [1:0]  idx;
  } exp_t;

  exp_t        sb[$];
  exp_t        e;
  int          checks = 0;
  int          failures = 0;
  int          ptr_m;
  logic [4:0]  last_addr;
  logic [31:0] last_data;
  logic [1:0]  last_idx;
  logic [3:0]  obs_ready;
  logic [3:0]  exp_ready;

  task automatic model_reset();
    ptr_m = 3;
    last_addr = '0;
    last_data = '0;
    last_idx = '0;
    sb.delete();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req_valid_i = '0;
    model_reset();
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  // Drive one cycle of requests, predict the grant, queue the expected outputs, advance past the edge.
  task automatic cycle(input logic [3:0] v, input logic [19:0] a, input logic [127:0] d);
    exp_t x;
    logic f;
    int w;
    req_valid_i = v; req_addr_i = a; req_data_i = d;
    #1;
    obs_ready = req_ready_o;
    f = 1'b0; w = 0;
    for (int i = 1; i <= 4; i++) begin
      int c;
      c = (ptr_m + i) % 4;
      if (!f && v[c]) begin f = 1'b1; w = c; end
    end
    exp_ready = f ? (4'b0001 << w) : 4'b0000;
    if (f) begin
      last_addr = a[w*5 +: 5];
      last_data = d[w*32 +: 32];
      last_idx  = 2'(w);
      ptr_m     = w;
    end
    x.en = f && (last_addr != 5'd0);
    x.addr = last_addr; x.data = last_data; x.idx = last_idx;
    sb.push_back(x);
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    model_reset();
    req_valid_i = 4'b1111;
    repeat (2) @(posedge clk);
    #3;
    checks++;
    if (req_ready_o !== 4'b0000) begin failures++; $display("FAIL reset_ready got=%b exp=0000", req_ready_o); end
    checks++;
    if ({rf_wr_en_o, rf_addr_o, rf_data_o, grant_idx_o} !== '0)
      begin failures++; $display("FAIL reset_outputs got en=%b addr=%0d data=%h idx=%0d exp all zero", rf_wr_en_o, rf_addr_o, rf_data_o, grant_idx_o); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    cycle(4'b1111, {5'd4, 5'd3, 5'd2, 5'd1}, {32'h4, 32'h3, 32'h2, 32'h1});
    checks++;
    if (obs_ready !== 4'b0001) begin failures++; $display("FAIL reset_first_ready got=%b exp=0001", obs_ready); end
    e = sb.pop_front();
    checks++;
    if (rf_wr_en_o !== 1'b1 || grant_idx_o !== 2'd0 || rf_addr_o !== 5'd1 || e.addr !== 5'd1)
      begin failures++; $display("FAIL reset_first_write got en=%b idx=%0d addr=%0d exp en=1 idx=0 addr=1", rf_wr_en_o, grant_idx_o, rf_addr_o); end
  endtask

  task automatic test_single();
    logic [19:0] a; logic [127:0] d;
    a = '0; d = '0;
    a[10 +: 5] = 5'd7; d[64 +: 32] = 32'hDEADBEEF;
    cycle(4'b0100, a, d);
    checks++;
    if (obs_ready !== 4'b0100) begin failures++; $display("FAIL single_ready got=%b exp=0100", obs_ready); end
    e = sb.pop_front();
    checks++;
    if (rf_wr_en_o !== 1'b1 || rf_addr_o !== 5'd7 || rf_data_o !== 32'hDEADBEEF || grant_idx_o !== 2'd2 || e.data !== 32'hDEADBEEF)
      begin failures++; $display("FAIL single_write got en=%b addr=%0d data=%h idx=%0d exp en=1 addr=7 data=deadbeef idx=2", rf_wr_en_o, rf_addr_o, rf_data_o, grant_idx_o); end
    cycle(4'b0000, a, d);
    checks++;
    if (obs_ready !== 4'b0000) begin failures++; $display("FAIL idle_ready got=%b exp=0000", obs_ready); end
    e = sb.pop_front();
    checks++;
    if ({rf_wr_en_o, rf_addr_o, rf_data_o, grant_idx_o} !== {e.en, e.addr, e.data, e.idx} || rf_wr_en_o !== 1'b0)
      begin failures++; $display("FAIL idle_hold got en=%b addr=%0d data=%h idx=%0d exp en=0 addr=%0d data=%h idx=%0d", rf_wr_en_o, rf_addr_o, rf_data_o, grant_idx_o, e.addr, e.data, e.idx); end
  endtask

  task automatic test_contention();
    logic [19:0] a; logic [127:0] d;
    do_reset();
    for (int n = 0; n < 8; n++) begin
      for (int k = 0; k < 4; k++) begin
        a[k*5 +: 5] = 5'(k + 8);
        d[k*32 +: 32] = 32'hA000_0000 + 32'(n*16 + k);
      end
      cycle(4'b1111, a, d);
      checks++;
      if (obs_ready !== (4'b0001 << (n % 4))) begin failures++; $display("FAIL contention_ready cycle=%0d got=%b exp=%b", n, obs_ready, 4'b0001 << (n % 4)); end
      e = sb.pop_front();
      checks++;
      if (rf_wr_en_o !== 1'b1 || grant_idx_o !== 2'(n % 4) || rf_addr_o !== e.addr || rf_data_o !== e.data)
        begin failures++; $display("FAIL contention_write cycle=%0d got en=%b idx=%0d addr=%0d data=%h exp en=1 idx=%0d addr=%0d data=%h", n, rf_wr_en_o, grant_idx_o, rf_addr_o, rf_data_o, n % 4, e.addr, e.data); end
    end
  endtask

  task automatic test_wrap();
    logic [19:0] a; logic [127:0] d;
    a = {5'd13, 5'd12, 5'd11, 5'd10};
    d = {32'h33, 32'h22, 32'h11, 32'h00};
    cycle(4'b0100, a, d);
    e = sb.pop_front();
    cycle(4'b1001, a, d);
    checks++;
    if (obs_ready !== 4'b1000) begin failures++; $display("FAIL wrap_first got=%b exp=1000", obs_ready); end
    e = sb.pop_front();
    checks++;
    if (grant_idx_o !== 2'd3 || rf_addr_o !== 5'd13 || rf_data_o !== 32'h33)
      begin failures++; $display("FAIL wrap_first_write got idx=%0d addr=%0d data=%h exp idx=3 addr=13 data=33", grant_idx_o, rf_addr_o, rf_data_o); end
    cycle(4'b1001, a, d);
    checks++;
    if (obs_ready !== 4'b0001) begin failures++; $display("FAIL wrap_second got=%b exp=0001", obs_ready); end
    e = sb.pop_front();
    checks++;
    if (grant_idx_o !== 2'd0 || rf_addr_o !== 5'd10 || rf_wr_en_o !== 1'b1)
      begin failures++; $display("FAIL wrap_second_write got idx=%0d addr=%0d en=%b exp idx=0 addr=10 en=1", grant_idx_o, rf_addr_o, rf_wr_en_o); end
  endtask

  task automatic test_x0();
    logic [19:0] a; logic [127:0] d;
    a = {5'd20, 5'd21, 5'd0, 5'd22};
    d = {32'h77, 32'h66, 32'h1234, 32'h55};
    cycle(4'b0010, a, d);
    checks++;
    if (obs_ready !== 4'b0010) begin failures++; $display("FAIL x0_ready got=%b exp=0010", obs_ready); end
    e = sb.pop_front();
    checks++;
    if (rf_wr_en_o !== 1'b0 || grant_idx_o !== 2'd1 || rf_addr_o !== 5'd0 || e.en !== 1'b0)
      begin failures++; $display("FAIL x0_suppress got en=%b idx=%0d addr=%0d exp en=0 idx=1 addr=0", rf_wr_en_o, grant_idx_o, rf_addr_o); end
    cycle(4'b0011, a, d);
    checks++;
    if (obs_ready !== exp_ready || obs_ready !== 4'b0001) begin failures++; $display("FAIL x0_ptr_advance got=%b exp=0001", obs_ready); end
    e = sb.pop_front();
  endtask

  task automatic test_reset_mid();
    logic [19:0] a; logic [127:0] d;
    a = '0; d = '0;
    a[15 +: 5] = 5'd9; d[96 +: 32] = 32'hCAFEF00D;
    cycle(4'b1000, a, d);
    e = sb.pop_front();
    checks++;
    if (rf_wr_en_o !== e.en || rf_wr_en_o !== 1'b1) begin failures++; $display("FAIL mid_pre_pulse got en=%b exp=1", rf_wr_en_o); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (rf_wr_en_o !== 1'b0 || rf_addr_o !== 5'd0 || rf_data_o !== 32'd0 || req_ready_o !== 4'b0000)
      begin failures++; $display("FAIL mid_async_clear got en=%b addr=%0d data=%h ready=%b exp all zero", rf_wr_en_o, rf_addr_o, rf_data_o, req_ready_o); end
    do_reset();
    cycle(4'b1000, a, d);
    checks++;
    if (obs_ready !== 4'b1000) begin failures++; $display("FAIL mid_after_release got=%b exp=1000", obs_ready); end
    e = sb.pop_front();
  endtask

  initial begin
    model_reset();
    test_reset();
    test_single();
    test_contention();
    test_wrap();
    test_x0();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
